// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//
// Shares the single-port data_memory between two requesters. Port 0 (pipeline MEM
// stage) has fixed priority. Port 1 (loader/debug master) is forced through after
// STARVE_LIMIT consecutive port-0 wins that happened while it was waiting.
// Each access takes an ACCESS cycle, where the command is on the memory bus and
// the owner sees gnt, followed by a RESP cycle, where a read returns rvalid.
// Arbitration runs in IDLE and in RESP, so back-to-back accesses issue every two
// cycles.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   rN_req/rN_we/rN_addr/rN_wdata     port N command; held until rN_gnt is seen
//   rN_gnt                            one-cycle pulse while port N's command is issued
//   rN_rvalid/rN_rdata                read response pulse and held read data
//   mem_read/mem_write                memory strobes, only high during ACCESS
//   mem_address/mem_write_data        registered command, held after the access
//   mem_read_data                     memory read data, valid during ACCESS

module data_memory_arbiter #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // Port 0: high priority
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   // Port 1: low priority
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   // data_memory side
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } state_e;

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic in_access;
   logic in_resp;
   logic arb_en;
   logic any_req;
   logic starved;
   logic win_valid;
   logic win_port;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   assign in_access = (state_q == StAccess);
   assign in_resp   = (state_q == StResp);
   assign arb_en    = (state_q == StIdle) || in_resp;
   assign any_req   = r0_req | r1_req;
   assign starved   = (starve_cnt_q == StarveMax);
   assign win_valid = arb_en & any_req;
   // Port 1 wins when it is alone, or when both request and it has waited long enough.
   assign win_port  = r1_req & (~r0_req | starved);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               state_d = StAccess;
            end
         end
         StAccess: begin
            state_d = StResp;
         end
         StResp: begin
            state_d = win_valid ? StAccess : StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      r0_gnt    = 1'b0;
      r1_gnt    = 1'b0;
      r0_rvalid = 1'b0;
      r1_rvalid = 1'b0;
      unique case (state_q)
         StAccess: begin
            mem_read  = ~cmd_we_q;
            mem_write = cmd_we_q;
            r0_gnt    = ~owner_q;
            r1_gnt    = owner_q;
         end
         StResp: begin
            // Writes complete silently; only reads get a response pulse.
            r0_rvalid = ~owner_q & ~cmd_we_q;
            r1_rvalid = owner_q & ~cmd_we_q;
         end
         default: begin
         end
      endcase
   end

   // The memory buses come straight from the command registers, so they hold
   // the last command through RESP and IDLE.
   assign mem_address    = cmd_addr_q;
   assign mem_write_data = cmd_wdata_q;
   assign r0_rdata       = rdata0_q;
   assign r1_rdata       = rdata1_q;

   // ------------------------------------------------------------------
   // Command, starvation and read-data next state
   // ------------------------------------------------------------------
   always_comb begin
      owner_d      = owner_q;
      cmd_we_d     = cmd_we_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_wdata_d  = cmd_wdata_q;
      starve_cnt_d = starve_cnt_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;

      if (win_valid) begin
         owner_d = win_port;
         if (win_port) begin
            cmd_we_d    = r1_we;
            cmd_addr_d  = r1_addr;
            cmd_wdata_d = r1_wdata;
         end else begin
            cmd_we_d    = r0_we;
            cmd_addr_d  = r0_addr;
            cmd_wdata_d = r0_wdata;
         end
      end

      // Counts port-0 wins that port 1 had to sit through.
      if (arb_en) begin
         if (!r1_req || win_port) begin
            starve_cnt_d = 4'd0;
         end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
         end
      end

      // Read data is sampled at the edge that closes ACCESS.
      if (in_access && !cmd_we_q) begin
         if (owner_q) begin
            rdata1_d = mem_read_data;
         end else begin
            rdata0_d = mem_read_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q      <= 1'b0;
         cmd_we_q     <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         starve_cnt_q <= 4'd0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         owner_q      <= owner_d;
         cmd_we_q     <= cmd_we_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         starve_cnt_q <= starve_cnt_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // ------------------------------------------------------------------
   // Exclusivity properties
   // ------------------------------------------------------------------
   a_strobe_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(mem_read && mem_write));
   a_gnt_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(r0_gnt && r1_gnt));
   a_rvalid_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(r0_rvalid && r1_rvalid));

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter: scripted and random requesters, a memory
// stand-in, and a transaction-level reference model checked every cycle.

module tb_data_memory_arbiter;

   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 8;
   localparam int unsigned LIM = 4;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          r0_req, r0_we, r0_gnt, r0_rvalid;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata, r0_rdata;
   logic          r1_req, r1_we, r1_gnt, r1_rvalid;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata, r1_rdata;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_write_data, mem_read_data;

   // Memory stand-in
   logic [DW-1:0] tb_mem [256] = '{default: '0};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Requester state
   req_t rq [2][$];
   bit   present [2];
   int   gap [2];
   bit   rand_gaps    = 1'b0;
   bit   watch_starve = 1'b0;
   int   log_port [$];
   int   log_cyc [$];

   // Reference model state
   logic [DW-1:0] ref_mem [256];
   bit            blocked;
   bit            inf_port;
   bit            inf_we;
   logic [AW-1:0] inf_addr;
   logic [DW-1:0] inf_wdata, inf_rdata;
   bit            pend_w;
   logic [AW-1:0] pend_addr;
   logic [DW-1:0] pend_data;
   int            starve;
   logic          exp_gnt [2];
   logic          exp_rv [2];
   logic [DW-1:0] exp_rdata [2];
   logic          exp_mr, exp_mw;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata;

   data_memory_arbiter #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .STARVE_LIMIT(LIM)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .r0_req        (r0_req),
      .r0_we         (r0_we),
      .r0_addr       (r0_addr),
      .r0_wdata      (r0_wdata),
      .r0_gnt        (r0_gnt),
      .r0_rvalid     (r0_rvalid),
      .r0_rdata      (r0_rdata),
      .r1_req        (r1_req),
      .r1_we         (r1_we),
      .r1_addr       (r1_addr),
      .r1_wdata      (r1_wdata),
      .r1_gnt        (r1_gnt),
      .r1_rvalid     (r1_rvalid),
      .r1_rdata      (r1_rdata),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_write_data(mem_write_data),
      .mem_read_data (mem_read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write) tb_mem[mem_address] <= mem_write_data;
   end
   assign mem_read_data = tb_mem[mem_address];

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic push(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      req_t r;
      r.we    = we;
      r.addr  = a;
      r.wdata = d;
      rq[p].push_back(r);
   endtask

   // Protocol-following requesters: hold a request until gnt, then drop it or
   // present the next one in the following cycle.
   task automatic update_requesters();
      logic seen [2];
      seen[0] = r0_gnt;
      seen[1] = r1_gnt;
      for (int p = 0; p < 2; p++) begin
         if (present[p] && seen[p]) begin
            void'(rq[p].pop_front());
            present[p] = 1'b0;
            gap[p] = rand_gaps ? int'($urandom_range(0, 3)) : 0;
         end
         if (!present[p] && rq[p].size() > 0) begin
            if (gap[p] == 0) present[p] = 1'b1;
            else gap[p]--;
         end
      end
      if (present[0]) begin
         r0_req = 1'b1; r0_we = rq[0][0].we; r0_addr = rq[0][0].addr; r0_wdata = rq[0][0].wdata;
      end else begin
         r0_req = 1'b0; r0_we = 1'($urandom); r0_addr = AW'($urandom); r0_wdata = DW'($urandom);
      end
      if (present[1]) begin
         r1_req = 1'b1; r1_we = rq[1][0].we; r1_addr = rq[1][0].addr; r1_wdata = rq[1][0].wdata;
      end else begin
         r1_req = 1'b0; r1_we = 1'($urandom); r1_addr = AW'($urandom); r1_wdata = DW'($urandom);
      end
   endtask

   task automatic model_reset();
      blocked  = 1'b0;
      pend_w   = 1'b0;
      starve   = 0;
      exp_mr   = 1'b0;
      exp_mw   = 1'b0;
      exp_addr = '0;
      exp_wdata = '0;
      for (int p = 0; p < 2; p++) begin
         exp_gnt[p]   = 1'b0;
         exp_rv[p]    = 1'b0;
         exp_rdata[p] = '0;
      end
   endtask

   // Predicts what the outputs look like after the next rising edge, given the
   // request inputs just driven.
   task automatic model_step();
      int            w;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      if (pend_w) ref_mem[pend_addr] = pend_data;
      pend_w = 1'b0;
      exp_gnt[0] = 1'b0; exp_gnt[1] = 1'b0;
      exp_rv[0]  = 1'b0; exp_rv[1]  = 1'b0;
      exp_mr = 1'b0;
      exp_mw = 1'b0;
      if (blocked) begin
         // This edge completes the access; the following cycle is its response.
         blocked = 1'b0;
         if (inf_we) begin
            pend_w = 1'b1; pend_addr = inf_addr; pend_data = inf_wdata;
         end else begin
            exp_rv[inf_port]    = 1'b1;
            exp_rdata[inf_port] = inf_rdata;
         end
      end else begin
         w = -1;
         if (r0_req && r1_req) w = (starve == int'(LIM)) ? 1 : 0;
         else if (r0_req) w = 0;
         else if (r1_req) w = 1;
         if (w == 0 && r1_req) starve = (starve < int'(LIM)) ? starve + 1 : int'(LIM);
         else starve = 0;
         if (w >= 0) begin
            we = (w == 1) ? r1_we : r0_we;
            a  = (w == 1) ? r1_addr : r0_addr;
            d  = (w == 1) ? r1_wdata : r0_wdata;
            inf_port  = (w == 1);
            inf_we    = we;
            inf_addr  = a;
            inf_wdata = d;
            inf_rdata = ref_mem[a];
            exp_gnt[w] = 1'b1;
            exp_mw    = we;
            exp_mr    = !we;
            exp_addr  = a;
            exp_wdata = d;
            blocked   = 1'b1;
         end
      end
   endtask

   task automatic compare_outputs();
      check_eq("r0_gnt", 64'(r0_gnt), 64'(exp_gnt[0]));
      check_eq("r1_gnt", 64'(r1_gnt), 64'(exp_gnt[1]));
      check_eq("r0_rvalid", 64'(r0_rvalid), 64'(exp_rv[0]));
      check_eq("r1_rvalid", 64'(r1_rvalid), 64'(exp_rv[1]));
      check_eq("r0_rdata", 64'(r0_rdata), 64'(exp_rdata[0]));
      check_eq("r1_rdata", 64'(r1_rdata), 64'(exp_rdata[1]));
      check_eq("mem_read", 64'(mem_read), 64'(exp_mr));
      check_eq("mem_write", 64'(mem_write), 64'(exp_mw));
      check_eq("mem_address", 64'(mem_address), 64'(exp_addr));
      check_eq("mem_write_data", 64'(mem_write_data), 64'(exp_wdata));
      check_eq("gnt_excl", 64'(r0_gnt & r1_gnt), 64'd0);
      check_eq("strobe_excl", 64'(mem_read & mem_write), 64'd0);
      if (r0_gnt) begin log_port.push_back(0); log_cyc.push_back(cyc); end
      if (r1_gnt) begin log_port.push_back(1); log_cyc.push_back(cyc); end
      if (watch_starve && r1_gnt) check_eq("starve_clr", 64'(dut.starve_cnt_q), 64'd0);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         compare_outputs();
         update_requesters();
         model_step();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_gnt"}, 64'({r0_gnt, r1_gnt}), 64'd0);
      check_eq({tag, "_rvalid"}, 64'({r0_rvalid, r1_rvalid}), 64'd0);
      check_eq({tag, "_strobes"}, 64'({mem_read, mem_write}), 64'd0);
      check_eq({tag, "_addr"}, 64'(mem_address), 64'd0);
      check_eq({tag, "_wdata"}, 64'(mem_write_data), 64'd0);
      check_eq({tag, "_rdata"}, 64'({r0_rdata, r1_rdata}), 64'd0);
   endtask

   // Called at a falling edge.
   task automatic release_reset();
      rst_n = 1'b1;
      model_reset();
      update_requesters();
      model_step();
   endtask

   task automatic abandon_requests();
      rq[0].delete();
      rq[1].delete();
      present[0] = 1'b0;
      present[1] = 1'b0;
      r0_req = 1'b0;
      r1_req = 1'b0;
   endtask

   initial begin
      logic [6:0] seq;
      bit         found;

      foreach (ref_mem[i]) ref_mem[i] = '0;
      r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
      r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(negedge clk);
      release_reset();

      // Port 0 write then read of address 2
      push(0, 1'b1, 8'd2, 16'd1);
      push(0, 1'b0, 8'd2, 16'hFFFF);
      run_cycles(8);
      check_eq("p0_readback", 64'(r0_rdata), 64'd1);

      // Port 1: store 0xDEAD at 8, then read it back alone
      push(1, 1'b1, 8'd8, 16'hDEAD);
      run_cycles(5);
      push(1, 1'b0, 8'd8, 16'h0000);
      run_cycles(6);
      check_eq("p1_readback", 64'(r1_rdata), 64'hDEAD);

      // Simultaneous requests: port 0 first, port 1 two cycles later
      log_port.delete(); log_cyc.delete();
      push(0, 1'b1, 8'd3, 16'h0303);
      push(1, 1'b0, 8'd4, 16'h0000);
      run_cycles(8);
      check_eq("simul_count", 64'(log_port.size()), 64'd2);
      if (log_port.size() == 2) begin
         check_eq("simul_first", 64'(log_port[0]), 64'd0);
         check_eq("simul_gap", 64'(log_cyc[1] - log_cyc[0]), 64'd2);
      end

      // Starvation: 4 port-0 grants, then port 1, then port 0 resumes
      log_port.delete(); log_cyc.delete();
      watch_starve = 1'b1;
      for (int i = 0; i < 6; i++) push(0, 1'($urandom), AW'(i), DW'($urandom));
      push(1, 1'b0, 8'd3, 16'h0000);
      run_cycles(20);
      watch_starve = 1'b0;
      check_eq("starve_count", 64'(log_port.size()), 64'd7);
      seq = '0;
      for (int i = 0; i < log_port.size() && i < 7; i++) seq[i] = (log_port[i] == 1);
      check_eq("starve_order", 64'(seq), 64'h10);

      // Reset in the middle of a port-1 write to address 5
      push(1, 1'b1, 8'd5, 16'h0055);
      run_cycles(6);
      push(1, 1'b1, 8'd5, 16'hBEEF);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         run_cycles(1);
         found = r1_gnt;
      end
      check_eq("abort_gnt_seen", 64'(found), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_eq("abort_mem_write", 64'(mem_write), 64'd0);
      check_eq("abort_r1_gnt", 64'(r1_gnt), 64'd0);
      abandon_requests();
      repeat (2) @(negedge clk);
      release_reset();
      run_cycles(4);
      check_eq("abort_mem5", 64'(tb_mem[5]), 64'h0055);

      // Random traffic
      rand_gaps = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 2) == 0 && rq[0].size() < 3)
            push(0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
         if ($urandom_range(0, 2) == 0 && rq[1].size() < 3)
            push(1, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
         run_cycles(1);
      end
      run_cycles(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
